tv80_bus_ctrl: RTL and testbench

//  Downstream stage of the TV80 core. Turns raw core cycle status (mc/ts one-hot,

---
 rtl/tv80_bus_ctrl.sv | 174 +++++++++++++++++
 tb/tb_tv80_bus_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tv80_bus_ctrl.sv
// TV80 bus controller: turns the core's M-cycle/T-state status into registered
// Z80-style bus strobes, holds read data for the core, and inserts wait states.
//
// Wait FSM
//   state   | meaning
//   --------+----------------------------------------------------------
//   W_IDLE  | no wait pending, cnt is zero
//   W_LOAD  | cnt just loaded at the T1 edge of a fetch/memory/IO cycle
//   W_COUNT | cnt decrementing once per cen edge while the core sits in T2
module tv80_bus_ctrl #(
    parameter int M1_WAIT  = 0,
    parameter int MEM_WAIT = 0,
    parameter int IO_WAIT  = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cen,
    input  logic        m1_n,
    input  logic        iorq,
    input  logic        no_read,
    input  logic        write,
    input  logic        rfsh_n,
    input  logic        intcycle_n,
    input  logic        busak_n,
    input  logic [6:0]  mc,
    input  logic [6:0]  ts,
    input  logic [15:0] A,
    input  logic [7:0]  dout,
    output logic [7:0]  core_di,
    output logic        core_wait_n,
    output logic        mreq_n,
    output logic        iorq_n,
    output logic        rd_n,
    output logic        wr_n,
    output logic [15:0] bus_a,
    output logic [7:0]  bus_do,
    input  logic [7:0]  bus_di,
    input  logic        ext_wait_n
);

    typedef enum logic [2:0] {C_NONE, C_FETCH, C_INTA, C_MEM, C_IO} cyc_t;
    typedef enum logic [1:0] {W_IDLE, W_LOAD, W_COUNT} wstate_t;

    localparam logic [3:0] M1_W  = 4'(M1_WAIT);
    localparam logic [3:0] MEM_W = 4'(MEM_WAIT);
    localparam logic [3:0] IO_W  = 4'(IO_WAIT);

    cyc_t       cls_now, cls_q, cls;
    logic       wr_q, wr;
    logic [3:0] strobe_d;          // {mreq_n, iorq_n, rd_n, wr_n}
    wstate_t    state, state_d;
    logic [3:0] cnt, cnt_d;
    logic [3:0] wait_val;
    logic       load_cls;
    logic       unused_inputs;

    // Only mc[0] and ts[0..2] carry information this stage needs.
    assign unused_inputs = ^{m1_n, mc[6:1], ts[6:3]};

    assign bus_a       = A;
    assign core_wait_n = (cnt == 4'd0) & ext_wait_n;

    // Classify the cycle from the live status; only meaningful at T1.
    always_comb begin
        cls_now = C_NONE;
        if (mc[0])
            cls_now = intcycle_n ? C_FETCH : C_INTA;
        else if (iorq)
            cls_now = C_IO;
        else if (write | ~no_read)
            cls_now = C_MEM;
    end

    // At T1 the class is still being latched, so use the live one there.
    assign cls = ts[0] ? cls_now : cls_q;
    assign wr  = ts[0] ? write   : wr_q;

    // Strobe decode for the current T-state; write wins over read.
    always_comb begin
        strobe_d = 4'b1111;
        unique case (cls)
            C_FETCH: begin
                if (ts[0] | ts[1])
                    strobe_d = 4'b0101;
                else if (ts[2] && !rfsh_n)
                    strobe_d = 4'b0111;
            end
            C_INTA: begin
                if (ts[1] | ts[2])
                    strobe_d = 4'b1011;
            end
            C_MEM, C_IO: begin
                if (ts[0] | ts[1]) begin
                    if (cls == C_MEM)
                        strobe_d[3] = 1'b0;
                    else
                        strobe_d[2] = 1'b0;
                    if (wr)
                        strobe_d[0] = ~ts[1];
                    else
                        strobe_d[1] = 1'b0;
                end
            end
            default: ;
        endcase
        if (!busak_n)
            strobe_d = 4'b1111;
    end

    // Wait-state counter next-state logic.
    always_comb begin
        load_cls = (cls_now == C_FETCH) | (cls_now == C_MEM) | (cls_now == C_IO);
        unique case (cls_now)
            C_FETCH: wait_val = M1_W;
            C_MEM:   wait_val = MEM_W;
            C_IO:    wait_val = IO_W;
            default: wait_val = 4'd0;
        endcase
        state_d = state;
        cnt_d   = cnt;
        if (!busak_n) begin
            state_d = W_IDLE;
            cnt_d   = 4'd0;
        end else if (ts[0] && load_cls) begin
            state_d = W_LOAD;
            cnt_d   = wait_val;
        end else begin
            unique case (state)
                W_LOAD, W_COUNT: begin
                    if (cnt == 4'd0) begin
                        state_d = W_IDLE;
                    end else if (ts[1]) begin
                        state_d = W_COUNT;
                        cnt_d   = cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Wait FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= W_IDLE;
            cnt   <= 4'd0;
        end else if (cen) begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Registered strobes, latched cycle class and data registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {mreq_n, iorq_n, rd_n, wr_n} <= 4'b1111;
            cls_q   <= C_NONE;
            wr_q    <= 1'b0;
            core_di <= 8'h00;
            bus_do  <= 8'h00;
        end else if (cen) begin
            {mreq_n, iorq_n, rd_n, wr_n} <= strobe_d;
            if (ts[0]) begin
                cls_q <= cls_now;
                wr_q  <= write;
            end
            if (ts[0] && !mc[0] && write)
                bus_do <= dout;
            if (ts[1] && core_wait_n && !rd_n)
                core_di <= bus_di;
        end
    end

endmodule

// File: tb/tb_tv80_bus_ctrl.sv
// Bench for tv80_bus_ctrl: a small core model walks bus cycles T-state by
// T-state, a reference model predicts the bus outputs from the cycle rules,
// and one compare process checks the DUT every clock.
module tb_tv80_bus_ctrl;
    localparam int M1W = 0, MEMW = 2, IOW = 1;
    localparam int K_NONE = 0, K_FETCH = 1, K_INTA = 2, K_MEM = 3, K_IO = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cen = 1'b1;
    logic        m1_n = 1'b1, iorq = 1'b0, no_read = 1'b1, write = 1'b0;
    logic        rfsh_n = 1'b1, intcycle_n = 1'b1, busak_n = 1'b1;
    logic [6:0]  mc = 7'd0, ts = 7'd0;
    logic [15:0] A = 16'h0000;
    logic [7:0]  dout = 8'h00, bus_di = 8'h00;
    logic        ext_wait_n = 1'b1;
    logic [7:0]  core_di, bus_do;
    logic        core_wait_n, mreq_n, iorq_n, rd_n, wr_n;
    logic [15:0] bus_a;

    tv80_bus_ctrl #(.M1_WAIT(M1W), .MEM_WAIT(MEMW), .IO_WAIT(IOW)) dut (
        .clk(clk), .reset_n(reset_n), .cen(cen), .m1_n(m1_n), .iorq(iorq),
        .no_read(no_read), .write(write), .rfsh_n(rfsh_n), .intcycle_n(intcycle_n),
        .busak_n(busak_n), .mc(mc), .ts(ts), .A(A), .dout(dout), .core_di(core_di),
        .core_wait_n(core_wait_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n),
        .wr_n(wr_n), .bus_a(bus_a), .bus_do(bus_do), .bus_di(bus_di),
        .ext_wait_n(ext_wait_n)
    );

    always #5 clk = ~clk;

    // Core-side view of where we are in the bus cycle (t = 1-based T-state).
    int cur_cls = K_NONE;
    int cur_t = 0;
    bit cur_wr = 1'b0;

    // Reference model state.
    logic [3:0] exp_str;     // {mreq_n, iorq_n, rd_n, wr_n}
    logic [7:0] exp_di, exp_do;
    int         rem;         // wait states still owed
    bit         adv;         // core may leave its current T-state at this edge
    logic       wait_ok;
    assign wait_ok = (rem == 0) && ext_wait_n;

    // Which strobes a cycle asserts after the edge at T-state t (1 = active).
    function automatic logic [3:0] active(int c, bit w, int t, logic rf);
        logic [3:0] req;
        if (c == K_FETCH)
            return (t == 1 || t == 2) ? 4'b1010 : (t == 3 && !rf) ? 4'b1000 : 4'b0000;
        if (c == K_INTA)
            return (t == 2 || t == 3) ? 4'b0100 : 4'b0000;
        if (c == K_MEM || c == K_IO) begin
            req = (c == K_MEM) ? 4'b1000 : 4'b0100;
            if (t == 1) return req | (w ? 4'b0000 : 4'b0010);
            if (t == 2) return req | (w ? 4'b0001 : 4'b0010);
        end
        return 4'b0000;
    endfunction

    function automatic int waits_for(int c);
        return (c == K_FETCH) ? M1W : (c == K_MEM) ? MEMW : (c == K_IO) ? IOW : 0;
    endfunction

    // Reference model: advances only on cen edges, like the core.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_str <= 4'b1111;
            exp_di  <= 8'h00;
            exp_do  <= 8'h00;
            rem     <= 0;
            adv     <= 1'b0;
        end else if (cen) begin
            exp_str <= busak_n ? ~active(cur_cls, cur_wr, cur_t, rfsh_n) : 4'b1111;
            if (cur_t == 2 && wait_ok && !exp_str[1])
                exp_di <= bus_di;
            if (cur_t == 1 && cur_wr)
                exp_do <= dout;
            if (!busak_n)
                rem <= 0;
            else if (cur_t == 1 && waits_for(cur_cls) >= 0 &&
                     (cur_cls == K_FETCH || cur_cls == K_MEM || cur_cls == K_IO))
                rem <= waits_for(cur_cls);
            else if (cur_t == 2 && rem > 0)
                rem <= rem - 1;
            adv <= !(cur_t == 2 && !wait_ok);
        end else begin
            adv <= 1'b0;
        end
    end

    int vectors = 0, miscompares = 0;
    bit chk_on = 1'b0;
    int n_rd = 0, n_mreq = 0, n_iorq = 0, n_wait = 0;

    // Hand-computed expectations are posted here and checked by the compare loop.
    bit          pin_req = 1'b0, pin_ack = 1'b0;
    int          pin_id = 0;
    logic [15:0] pin_act, pin_exp;
    string pin_names [16] = '{"rst_strobes", "rst_core_di", "fetch_core_di", "fetch_rd_lo_clks",
        "fetch_mreq_lo_clks", "memwr_wait_lo_clks", "memwr_bus_do", "memwr_rd_lo_clks",
        "ioread_core_di", "ioread_iorq_lo_clks", "ioread_mreq_lo_clks", "inta_iorq_lo_clks",
        "inta_core_di", "inta_mreq_rd_lo_clks", "cen3_rd_lo_clks", "cen3_core_di"};

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process, sampling on the falling edge.
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("mreq_n", 16'(mreq_n), 16'(exp_str[3]));
            chk("iorq_n", 16'(iorq_n), 16'(exp_str[2]));
            chk("rd_n", 16'(rd_n), 16'(exp_str[1]));
            chk("wr_n", 16'(wr_n), 16'(exp_str[0]));
            chk("core_wait_n", 16'(core_wait_n), 16'(wait_ok));
            chk("core_di", 16'(core_di), 16'(exp_di));
            chk("bus_do", 16'(bus_do), 16'(exp_do));
            chk("bus_a", bus_a, A);
            chk("rd_wr_exclusive", 16'(!rd_n && !wr_n), 16'd0);
            if (!rd_n) n_rd++;
            if (!mreq_n) n_mreq++;
            if (!iorq_n) n_iorq++;
            if (!core_wait_n) n_wait++;
        end
        if (pin_req != pin_ack) begin
            chk(pin_names[pin_id], pin_act, pin_exp);
            pin_ack = pin_req;
        end
    end

    task automatic pin(input int id, input logic [15:0] act, input logic [15:0] exp);
        pin_id  = id;
        pin_act = act;
        pin_exp = exp;
        pin_req = ~pin_req;
        @(negedge clk);
        #1;
    endtask

    // Drive one bus cycle; the core stalls in T2 while the model says wait.
    task automatic run_cycle(input int c, input bit w, input logic [15:0] a,
                             input logic [7:0] d, input logic [7:0] bdi,
                             input int ext_n, input int div, input bit rnd_busak);
        int t, k, nt, ext_left;
        nt = (c == K_FETCH || c == K_INTA) ? 4 : 3;
        t = 1; k = 0; ext_left = ext_n;
        cur_cls = c;
        cur_wr = w && (c == K_MEM || c == K_IO);
        A = a; dout = d; bus_di = bdi;
        mc = (c == K_FETCH || c == K_INTA) ? 7'b0000001 : 7'b0000010;
        iorq = (c == K_IO);
        write = cur_wr;
        no_read = (c == K_NONE) ? 1'b1 : (cur_wr ? 1'($urandom_range(0, 1)) : 1'b0);
        intcycle_n = (c != K_INTA);
        while (t <= nt) begin
            cur_t = t;
            ts = 7'(1 << (t - 1));
            m1_n = !((c == K_FETCH || c == K_INTA) && t <= 2);
            rfsh_n = !(c == K_FETCH && t >= 3);
            ext_wait_n = !(t == 2 && ext_left > 0);
            cen = (k % div == 0);
            busak_n = rnd_busak ? ($urandom_range(0, 29) != 0) : 1'b1;
            @(posedge clk);
            #1;
            if (cen && t == 2 && ext_left > 0) ext_left--;
            if (adv) t++;
            k++;
            if (k > 400) begin
                $display("FAIL cycle_timeout: got stuck at T%0d expected completion", t);
                $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
                $fatal(1, "timeout");
            end
        end
        busak_n = 1'b1;
        ext_wait_n = 1'b1;
        cen = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int b_rd, b_mreq, b_iorq, b_wait;
        #12 chk_on = 1'b1;
        #10 reset_n = 1'b1;
        @(posedge clk); #1;

        // Reset arriving mid-fetch, after a previous capture of 77.
        run_cycle(K_FETCH, 0, 16'h0100, 8'h00, 8'h77, 0, 1, 0);
        cur_cls = K_FETCH; cur_wr = 1'b0; mc = 7'b0000001; intcycle_n = 1'b1;
        cur_t = 1; ts = 7'b0000001; m1_n = 1'b0;
        @(posedge clk); #1;
        cur_t = 2; ts = 7'b0000010;
        #2 reset_n = 1'b0;
        #1;
        pin(0, {12'd0, mreq_n, iorq_n, rd_n, wr_n}, 16'h000F);
        pin(1, 16'(core_di), 16'h0000);
        cur_cls = K_NONE; cur_t = 0; ts = 7'd0; mc = 7'd0; m1_n = 1'b1;
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;

        // Plain fetch, no waits.
        b_rd = n_rd; b_mreq = n_mreq;
        run_cycle(K_FETCH, 0, 16'h1234, 8'h00, 8'h3E, 0, 1, 0);
        pin(2, 16'(core_di), 16'h003E);
        pin(3, 16'(n_rd - b_rd), 16'd2);
        pin(4, 16'(n_mreq - b_mreq), 16'd3);

        // Memory write with two wait states.
        b_wait = n_wait; b_rd = n_rd;
        run_cycle(K_MEM, 1, 16'h8000, 8'hA5, 8'h11, 0, 1, 0);
        pin(5, 16'(n_wait - b_wait), 16'd2);
        pin(6, 16'(bus_do), 16'h00A5);
        pin(7, 16'(n_rd - b_rd), 16'd0);

        // I/O read, one programmed wait plus external wait held for 3 edges.
        b_iorq = n_iorq; b_mreq = n_mreq;
        run_cycle(K_IO, 0, 16'h00FE, 8'h00, 8'h5C, 3, 1, 0);
        pin(8, 16'(core_di), 16'h005C);
        pin(9, 16'(n_iorq - b_iorq), 16'd5);
        pin(10, 16'(n_mreq - b_mreq), 16'd0);

        // Interrupt acknowledge: no read strobe, no capture, no wait.
        b_iorq = n_iorq; b_mreq = n_mreq; b_rd = n_rd;
        run_cycle(K_INTA, 0, 16'h0038, 8'h00, 8'hFF, 0, 1, 0);
        pin(11, 16'(n_iorq - b_iorq), 16'd2);
        pin(12, 16'(core_di), 16'h005C);
        pin(13, 16'((n_mreq - b_mreq) + (n_rd - b_rd)), 16'd0);

        // Fetch with cen active one clock in three.
        b_rd = n_rd;
        run_cycle(K_FETCH, 0, 16'h2000, 8'h00, 8'hC9, 0, 3, 0);
        pin(14, 16'(n_rd - b_rd), 16'd6);
        pin(15, 16'(core_di), 16'h00C9);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            run_cycle(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                      16'($urandom), 8'($urandom), 8'($urandom),
                      int'($urandom_range(0, 2)), int'($urandom_range(1, 3)), 1'b1);
        end

        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
